// File: rtl/gc_cntr_if.sv
// Handshake-free control/status bundle for gc_cntr: load/count controls in, binary + Gray count out.
interface gc_cntr_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             load;
  logic             load_gc;
  logic             updn;
  logic [WIDTH-1:0] num;
  logic [WIDTH-1:0] cntr;
  logic [WIDTH-1:0] gc;
  logic             tc;
  logic             at_max;
  logic             at_min;

  modport master (
    output en, load, load_gc, updn, num,
    input  cntr, gc, tc, at_max, at_min
  );

  modport slave (
    input  en, load, load_gc, updn, num,
    output cntr, gc, tc, at_max, at_min
  );
endinterface

// File: rtl/gc_cntr.sv
// Up/down modulo-(LIMIT+1) counter with flop-driven Gray output, wrap/saturate modes and tc pulse.
// cntr/gc/tc update one cycle after inputs are sampled; at_max/at_min decode the current count.
module gc_cntr #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] LIMIT    = {WIDTH{1'b1}},
  parameter bit               SATURATE = 1'b0,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input logic      clk,
  input logic      rstn,
  gc_cntr_if.slave cnt_if
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("gc_cntr: WIDTH must be in 2..32");
  end

  localparam logic [WIDTH-1:0] RST_GC = RST_VAL ^ (RST_VAL >> 1);

  logic [WIDTH-1:0] cntr_q, cntr_d;
  logic [WIDTH-1:0] gc_q, gc_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] tgt_bin;
  logic [WIDTH-1:0] tgt;
  logic [WIDTH-1:0] load_val;

  // Each binary bit is the XOR of all Gray bits at and above it.
  always_comb begin
    tgt_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      tgt_bin[i] = ^(cnt_if.num >> i);
    end
  end

  assign tgt      = cnt_if.load_gc ? tgt_bin : cnt_if.num;
  assign load_val = (tgt > LIMIT) ? LIMIT : tgt;

  always_comb begin
    cntr_d = cntr_q;
    tc_d   = 1'b0;
    if (cnt_if.load) begin
      cntr_d = load_val;
    end else if (cnt_if.en) begin
      if (cnt_if.updn) begin
        if (cntr_q != LIMIT) begin
          cntr_d = cntr_q + WIDTH'(1);
        end else begin
          tc_d   = 1'b1;
          cntr_d = SATURATE ? cntr_q : '0;
        end
      end else begin
        if (cntr_q != '0) begin
          cntr_d = cntr_q - WIDTH'(1);
        end else begin
          tc_d   = 1'b1;
          cntr_d = SATURATE ? cntr_q : LIMIT;
        end
      end
    end
  end

  // Gray comes from next-state so both registers always agree.
  assign gc_d = cntr_d ^ (cntr_d >> 1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cntr_q <= RST_VAL;
      gc_q   <= RST_GC;
      tc_q   <= 1'b0;
    end else begin
      cntr_q <= cntr_d;
      gc_q   <= gc_d;
      tc_q   <= tc_d;
    end
  end

  assign cnt_if.cntr   = cntr_q;
  assign cnt_if.gc     = gc_q;
  assign cnt_if.tc     = tc_q;
  assign cnt_if.at_max = (cntr_q == LIMIT);
  assign cnt_if.at_min = (cntr_q == '0);

endmodule

// File: tb/tb_gc_cntr.sv
// Directed bench for gc_cntr: default 8-bit wrap, 4-bit LIMIT=9 wrap and 4-bit LIMIT=9 saturate instances.
module tb_gc_cntr;

  logic clk;
  logic rstn;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  gc_cntr_if #(.WIDTH(8)) b8 ();
  gc_cntr_if #(.WIDTH(4)) bw ();
  gc_cntr_if #(.WIDTH(4)) bs ();

  gc_cntr u8 (.clk(clk), .rstn(rstn), .cnt_if(b8.slave));
  gc_cntr #(.WIDTH(4), .LIMIT(4'd9), .SATURATE(1'b0), .RST_VAL(4'd0))
    u4w (.clk(clk), .rstn(rstn), .cnt_if(bw.slave));
  gc_cntr #(.WIDTH(4), .LIMIT(4'd9), .SATURATE(1'b1), .RST_VAL(4'd0))
    u4s (.clk(clk), .rstn(rstn), .cnt_if(bs.slave));

  typedef struct {
    int         sel;
    logic       ld;
    logic       lgc;
    logic       en;
    logic       up;
    logic [7:0] num;
    logic [7:0] cntr;
    logic [7:0] gc;
    logic       tc;
    logic       amax;
    logic       amin;
  } vec_t;

  vec_t vt[$];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  function automatic vec_t mk(int sel, logic ld, logic lgc, logic en, logic up, logic [7:0] num,
                              logic [7:0] cntr, logic [7:0] gc, logic tc, logic amax, logic amin);
    vec_t v;
    v.sel = sel; v.ld = ld; v.lgc = lgc; v.en = en; v.up = up; v.num = num;
    v.cntr = cntr; v.gc = gc; v.tc = tc; v.amax = amax; v.amin = amin;
    return v;
  endfunction

  task automatic idle_all();
    b8.en = 0; b8.load = 0; b8.load_gc = 0; b8.updn = 0; b8.num = '0;
    bw.en = 0; bw.load = 0; bw.load_gc = 0; bw.updn = 0; bw.num = '0;
    bs.en = 0; bs.load = 0; bs.load_gc = 0; bs.updn = 0; bs.num = '0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic [7:0] c, g;
    logic       t, mx, mn;
    @(negedge clk);
    idle_all();
    case (v.sel)
      0: begin b8.load = v.ld; b8.load_gc = v.lgc; b8.en = v.en; b8.updn = v.up; b8.num = v.num; end
      1: begin bw.load = v.ld; bw.load_gc = v.lgc; bw.en = v.en; bw.updn = v.up; bw.num = v.num[3:0]; end
      default: begin bs.load = v.ld; bs.load_gc = v.lgc; bs.en = v.en; bs.updn = v.up; bs.num = v.num[3:0]; end
    endcase
    @(posedge clk);
    #1;
    case (v.sel)
      0: begin c = b8.cntr; g = b8.gc; t = b8.tc; mx = b8.at_max; mn = b8.at_min; end
      1: begin c = {4'h0, bw.cntr}; g = {4'h0, bw.gc}; t = bw.tc; mx = bw.at_max; mn = bw.at_min; end
      default: begin c = {4'h0, bs.cntr}; g = {4'h0, bs.gc}; t = bs.tc; mx = bs.at_max; mn = bs.at_min; end
    endcase
    check($sformatf("vec%0d.cntr", idx), 32'(c), 32'(v.cntr));
    check($sformatf("vec%0d.gc", idx), 32'(g), 32'(v.gc));
    check($sformatf("vec%0d.tc", idx), 32'(t), 32'(v.tc));
    check($sformatf("vec%0d.at_max", idx), 32'(mx), 32'(v.amax));
    check($sformatf("vec%0d.at_min", idx), 32'(mn), 32'(v.amin));
  endtask

  initial begin
    logic [7:0] e, prev_gc;

    // 8-bit: direction change, down wrap, Gray loads, load priority over en
    vt.push_back(mk(0, 1,0,0,0, 8'h02, 8'h02, 8'h03, 0, 0, 0));
    vt.push_back(mk(0, 0,0,1,0, 8'h00, 8'h01, 8'h01, 0, 0, 0));
    vt.push_back(mk(0, 0,0,1,0, 8'h00, 8'h00, 8'h00, 0, 0, 1));
    vt.push_back(mk(0, 0,0,1,0, 8'h00, 8'hFF, 8'h80, 1, 1, 0));
    vt.push_back(mk(0, 0,0,1,0, 8'h00, 8'hFE, 8'h81, 0, 0, 0));
    vt.push_back(mk(0, 0,0,1,1, 8'h00, 8'hFF, 8'h80, 0, 1, 0));
    vt.push_back(mk(0, 1,1,0,0, 8'hC0, 8'h80, 8'hC0, 0, 0, 0));
    vt.push_back(mk(0, 1,0,1,1, 8'h10, 8'h10, 8'h18, 0, 0, 0));
    vt.push_back(mk(0, 0,0,0,0, 8'h00, 8'h10, 8'h18, 0, 0, 0));
    vt.push_back(mk(0, 0,0,1,1, 8'h00, 8'h11, 8'h19, 0, 0, 0));
    vt.push_back(mk(0, 1,1,1,0, 8'hFF, 8'hAA, 8'hFF, 0, 0, 0));
    vt.push_back(mk(0, 0,0,0,1, 8'h00, 8'hAA, 8'hFF, 0, 0, 0));
    vt.push_back(mk(0, 0,0,1,1, 8'h00, 8'hAB, 8'hFE, 0, 0, 0));
    // 4-bit LIMIT=9 wrap
    vt.push_back(mk(1, 1,0,0,0, 8'h08, 8'h08, 8'h0C, 0, 0, 0));
    vt.push_back(mk(1, 0,0,1,1, 8'h00, 8'h09, 8'h0D, 0, 1, 0));
    vt.push_back(mk(1, 0,0,1,1, 8'h00, 8'h00, 8'h00, 1, 0, 1));
    vt.push_back(mk(1, 0,0,1,1, 8'h00, 8'h01, 8'h01, 0, 0, 0));
    vt.push_back(mk(1, 1,0,0,0, 8'h0E, 8'h09, 8'h0D, 0, 1, 0));
    vt.push_back(mk(1, 1,1,0,0, 8'h0F, 8'h09, 8'h0D, 0, 1, 0));
    vt.push_back(mk(1, 1,0,0,0, 8'h00, 8'h00, 8'h00, 0, 0, 1));
    vt.push_back(mk(1, 0,0,1,0, 8'h00, 8'h09, 8'h0D, 1, 1, 0));
    vt.push_back(mk(1, 1,1,0,0, 8'h05, 8'h06, 8'h05, 0, 0, 0));
    // 4-bit LIMIT=9 saturate
    vt.push_back(mk(2, 1,0,0,0, 8'h08, 8'h08, 8'h0C, 0, 0, 0));
    vt.push_back(mk(2, 0,0,1,1, 8'h00, 8'h09, 8'h0D, 0, 1, 0));
    vt.push_back(mk(2, 0,0,1,1, 8'h00, 8'h09, 8'h0D, 1, 1, 0));
    vt.push_back(mk(2, 0,0,1,1, 8'h00, 8'h09, 8'h0D, 1, 1, 0));
    vt.push_back(mk(2, 0,0,1,1, 8'h00, 8'h09, 8'h0D, 1, 1, 0));
    vt.push_back(mk(2, 0,0,0,1, 8'h00, 8'h09, 8'h0D, 0, 1, 0));
    vt.push_back(mk(2, 1,0,0,0, 8'h00, 8'h00, 8'h00, 0, 0, 1));
    vt.push_back(mk(2, 0,0,1,0, 8'h00, 8'h00, 8'h00, 1, 0, 1));
    vt.push_back(mk(2, 0,0,1,1, 8'h00, 8'h01, 8'h01, 0, 0, 0));

    // Reset takes effect before any clock edge
    rstn = 1'b0;
    idle_all();
    #3;
    check("rst.cntr", 32'(b8.cntr), 32'h00);
    check("rst.gc", 32'(b8.gc), 32'h00);
    check("rst.tc", 32'(b8.tc), 32'h0);
    check("rst.at_min", 32'(b8.at_min), 32'h1);
    check("rst.at_max", 32'(b8.at_max), 32'h0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Full 256-step up run with wrap
    prev_gc = 8'h00;
    for (int i = 1; i <= 256; i++) begin
      @(negedge clk);
      b8.en = 1'b1; b8.updn = 1'b1;
      @(posedge clk);
      #1;
      e = 8'(i);
      check($sformatf("run%0d.cntr", i), 32'(b8.cntr), 32'(e));
      check($sformatf("run%0d.gc", i), 32'(b8.gc), 32'(e ^ (e >> 1)));
      check($sformatf("run%0d.gc_1bit", i), 32'($countones(b8.gc ^ prev_gc)), 32'd1);
      check($sformatf("run%0d.tc", i), 32'(b8.tc), (i == 256) ? 32'd1 : 32'd0);
      prev_gc = b8.gc;
    end

    for (int k = 0; k < vt.size(); k++) apply(vt[k], k);

    // Async reset mid-count, with the saturating instance pushing so tc is high
    @(negedge clk);
    idle_all();
    b8.load = 1'b1; b8.num = 8'h36;
    bs.load = 1'b1; bs.num = 4'd9;
    @(negedge clk);
    idle_all();
    b8.en = 1'b1; b8.updn = 1'b1;
    bs.en = 1'b1; bs.updn = 1'b1;
    @(posedge clk);
    #1;
    check("pre_rst.cntr", 32'(b8.cntr), 32'h37);
    check("pre_rst.sat_tc", 32'(bs.tc), 32'h1);
    #2;
    rstn = 1'b0;
    #1;
    check("arst.cntr", 32'(b8.cntr), 32'h00);
    check("arst.gc", 32'(b8.gc), 32'h00);
    check("arst.at_min", 32'(b8.at_min), 32'h1);
    check("arst.sat_tc", 32'(bs.tc), 32'h0);
    check("arst.sat_cntr", 32'(bs.cntr), 32'h0);
    @(negedge clk);
    idle_all();
    rstn = 1'b1;
    @(negedge clk);
    b8.en = 1'b1; b8.updn = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst.cntr", 32'(b8.cntr), 32'h01);
    check("post_rst.tc", 32'(b8.tc), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/gc_cntr.md
# gc_cntr

Parametrised up/down counter with a registered Gray-code output, for pointers and position counters that cross clock domains in the audio datapath. It generalises the team's fixed 8-bit Gray counter with:
- configurable width and modulus;
- wrap or saturate mode and a count enable;
- loading in either binary or Gray encoding;
- a registered terminal-count pulse and boundary flags.

The Gray output is taken directly from flops, so it is glitch-free and safe to synchronise.

## Interface
- WIDTH, 8, counter width in bits; legal range 2..32.
- LIMIT, 2**WIDTH-1, maximum count value. The counter runs modulo LIMIT+1 and LIMIT must be at most 2**WIDTH-1.
- SATURATE, 0: 0 selects wrap mode, 1 selects saturate mode.
- RST_VAL, 0, count value after reset; must be at most LIMIT.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- en  in  1  count enable; counts one step per cycle while high.
- load  in  1  synchronous load; has priority over en.
- load_gc  in  1  when high, num is taken as Gray-encoded; only sampled while load=1.
- updn  in  1  direction: 1 counts up, 0 counts down.
- num  in  WIDTH  load value.
- cntr  out  WIDTH  binary count, registered.
- gc  out  WIDTH  Gray encoding of cntr, registered.
- tc  out  1  registered one-cycle pulse on a wrap or a saturation hit.
- at_max  out  1  combinational; high when cntr == LIMIT.
- at_min  out  1  combinational; high when cntr == 0.

## Operation
- Gray encoding: gc = cntr ^ (cntr >> 1). gc is loaded from the next-state value on the same edge as cntr, so gc == bin2gray(cntr) holds in every cycle.
- Gray-to-binary conversion for loads: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i].
- Next-state priority, evaluated each rising edge:
  1. load=1: target = load_gc ? gray2bin(num) : num. If target > LIMIT, cntr takes LIMIT; otherwise cntr takes target. tc=0. en and updn are ignored.
  2. en=1, updn=1:
     - cntr < LIMIT: cntr+1, tc=0.
     - cntr == LIMIT, wrap mode: cntr goes to 0, tc=1.
     - cntr == LIMIT, saturate mode: cntr holds, tc=1.
  3. en=1, updn=0:
     - cntr > 0: cntr-1, tc=0.
     - cntr == 0, wrap mode: cntr goes to LIMIT, tc=1.
     - cntr == 0, saturate mode: cntr holds, tc=1.
  4. en=0: cntr holds, tc=0.
- Arithmetic is WIDTH bits, unsigned. The limit compare happens before the increment, so no carry-out is ever used.
- Saturate mode: tc re-asserts on every enabled cycle that pushes against the bound. It is a level for as long as the push continues, not a single-shot pulse.
- A direction change needs no idle cycle; each enabled cycle uses the updn value sampled on that edge.
- With a non-power-of-two modulus, the wrap step (LIMIT to 0, or 0 to LIMIT) can change more than one gc bit. Users relying on single-bit-change CDC must set LIMIT = 2**WIDTH-1.

## Timing
- Reset asserted: cntr=RST_VAL, gc=bin2gray(RST_VAL), tc=0 immediately, independent of clk. at_max and at_min follow the reset value.
- Deassertion: the first active edge is the first rising clk edge with rstn=1.
- Reset mid-count: state is discarded and no tc is emitted.
- Latency:
  - cntr, gc and tc update one cycle after the controlling inputs are sampled.
  - at_max and at_min are valid in the same cycle as cntr, with no extra delay.
- Throughput: one step per cycle while en=1.
- A load and the end of an enable run can occur in the same cycle; the load wins, with no count and no tc.

## Test plan
- Reset, defaults: hold rstn=0 -> cntr=0x00, gc=0x00, tc=0, at_min=1. Release and run en=1, updn=1 for 256 cycles -> cntr sequences 0x00..0xFF then 0x00. gc changes exactly one bit per step, including 0xFF to 0x00 (gc 0x80 to 0x00). tc is high only on the cycle cntr becomes 0x00.
- Down wrap and direction change: load num=0x02, then en=1, updn=0 for 4 cycles -> cntr 0x01, 0x00, 0xFF, 0xFE, with tc=1 only when 0xFF appears. Toggle updn=1 -> next cntr=0xFF.
- Gray load: load=1, load_gc=1, num=0xC0 -> cntr=0x80, gc=0xC0. With load=1, en=1 and updn=1 in the same cycle -> load wins and cntr=num.
- WIDTH=4, LIMIT=9, SATURATE=0:
  - Counting up from 8 -> cntr 9, 0, 1, with tc=1 on the cycle cntr returns to 0.
  - Load num=14 -> cntr=9, at_max=1.
- WIDTH=4, LIMIT=9, SATURATE=1, counting up from 8 for 4 cycles -> cntr 9, 9, 9, 9. tc is 0, 1, 1, 1 (high on each push past the bound). gc stays constant at 0xD.
- Async reset mid-count: at cntr=0x37, pulse rstn low between clock edges -> cntr=RST_VAL and tc=0 immediately, not waiting for the next edge.
